// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Purpose:
//   Shares one single-port synchronous data RAM between the pipeline MEM
//   stage (CPU port) and the program/data loader (LD port). Each access
//   takes three cycles: IDLE (arbitrate and latch), ACCESS (drive the RAM),
//   RESP (one-cycle ack with read data). CPU has fixed priority. A
//   starvation counter forces a loader grant after STARVE_LIMIT contested
//   losses.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   cpu_*           CPU request (req/we/addr/wdata in, rdata/ack/stall out)
//   ld_*            loader request (req/we/addr/wdata in, rdata/ack out)
//   ram_addr/din/we RAM word address, write data and write enable
//   ram_dout        RAM read data, valid the cycle after the address
module dmem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              grant_ld_q, grant_ld_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        starve_q, starve_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       ld_rdata_q, ld_rdata_d;
    logic              ld_wins;
    logic [31:0]       resp_data;

    // Byte-lane bits and address bits above the RAM are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    // Next-state logic: arbitration and request latching happen only in IDLE.
    always_comb begin
        state_d    = state_q;
        grant_ld_d = grant_ld_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        ld_wins    = ld_req && (!cpu_req || (starve_q == LIMIT));

        case (state_q)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    state_d    = ACCESS;
                    grant_ld_d = ld_wins;
                    if (ld_wins) begin
                        we_d     = ld_we;
                        addr_d   = ld_addr[ADDR_W+1:2];
                        wdata_d  = ld_wdata;
                        starve_d = 4'd0;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr[ADDR_W+1:2];
                        wdata_d = cpu_wdata;
                        // Only a contested CPU win counts against the loader.
                        if (ld_req && (starve_q != LIMIT)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM output register only becomes valid in RESP, so the granted
    // requester sees ram_dout forwarded during RESP; the rdata registers
    // then hold that value until the requester's next completion.
    always_comb begin
        resp_data   = we_q ? 32'd0 : ram_dout;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        if (state_q == RESP) begin
            if (grant_ld_q) begin
                ld_rdata_d = resp_data;
            end else begin
                cpu_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_ld_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            starve_q    <= 4'd0;
            cpu_rdata_q <= 32'd0;
            ld_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            grant_ld_q  <= grant_ld_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
    assign ram_we    = (state_q == ACCESS) && we_q;
    assign cpu_ack   = (state_q == RESP) && !grant_ld_q;
    assign ld_ack    = (state_q == RESP) && grant_ld_q;
    assign cpu_rdata = cpu_rdata_d;
    assign ld_rdata  = ld_rdata_d;
    // Stall stays high while the loader owns the RAM and drops on our ack.
    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Purpose:
//   Self-checking bench for dmem_arbiter. A synchronous RAM model sits on the
//   RAM port. A transaction-level reference (one outstanding access, next
//   arbitration three cycles after the last one, starvation count) predicts
//   every output on every cycle. Directed sequences pin that reference with
//   literal values, and a randomized phase exercises both requesters.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 11;
    localparam int STARVE_LIMIT = 4;
    localparam int WORDS        = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0]       ld_addr = 32'd0, ld_wdata = 32'd0;
    logic [31:0]       ld_rdata;
    logic              ld_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_rdata  (ld_rdata),
        .ld_ack    (ld_ack),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    // Power-on contents of the RAM; word 5 carries a known marker.
    function automatic logic [31:0] initWord(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Single-port synchronous RAM, read-first, one-cycle read latency.
    logic        preload = 1'b1;
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= initWord(i);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_din;
        end
        ram_dout <= ram[ram_addr];
    end

    // Reference model state: memory image, one outstanding transaction.
    logic [31:0]       mem [WORDS];
    int                cyc = 0;
    int                free_at = 0;
    int                starve = 0;
    bit                pending = 0;
    bit                p_ld, p_we;
    int                p_cyc;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0]       p_wdata;

    logic        e_cpu_ack, e_ld_ack, e_ram_we, e_cpu_stall;
    logic [31:0] e_ram_addr = 0, e_ram_din = 0, e_cpu_rdata = 0, e_ld_rdata = 0;

    logic        s_cpu_ack, s_ld_ack, s_ram_we, s_cpu_stall;
    logic [31:0] s_ram_addr, s_ram_din, s_cpu_rdata, s_ld_rdata;

    int nCompared = 0;
    int nMismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predicts this cycle's outputs from the transaction schedule, then
    // arbitrates any request seen while the RAM is free.
    task automatic modelStep();
        logic [31:0] rd;
        bit          ld_wins;
        e_cpu_ack = 1'b0;
        e_ld_ack  = 1'b0;
        e_ram_we  = 1'b0;
        if (!reset) begin
            pending     = 0;
            free_at     = 0;
            starve      = 0;
            e_ram_addr  = 32'd0;
            e_ram_din   = 32'd0;
            e_cpu_rdata = 32'd0;
            e_ld_rdata  = 32'd0;
        end else begin
            if (pending && cyc == p_cyc + 1) begin
                e_ram_addr = 32'(p_addr);
                e_ram_din  = p_wdata;
                e_ram_we   = p_we;
                if (p_we) mem[p_addr] = p_wdata;
            end
            if (pending && cyc == p_cyc + 2) begin
                rd = p_we ? 32'd0 : mem[p_addr];
                if (p_ld) begin
                    e_ld_ack   = 1'b1;
                    e_ld_rdata = rd;
                end else begin
                    e_cpu_ack   = 1'b1;
                    e_cpu_rdata = rd;
                end
                pending = 0;
            end
            if (!pending && cyc >= free_at && (cpu_req || ld_req)) begin
                ld_wins = ld_req && (!cpu_req || starve == STARVE_LIMIT);
                if (ld_wins) begin
                    starve  = 0;
                    p_we    = ld_we;
                    p_addr  = ld_addr[ADDR_W+1:2];
                    p_wdata = ld_wdata;
                end else begin
                    if (ld_req && starve < STARVE_LIMIT) starve++;
                    p_we    = cpu_we;
                    p_addr  = cpu_addr[ADDR_W+1:2];
                    p_wdata = cpu_wdata;
                end
                p_ld    = ld_wins;
                p_cyc   = cyc;
                pending = 1;
                free_at = cyc + 3;
            end
        end
        e_cpu_stall = cpu_req && !e_cpu_ack;
    endtask

    task automatic checkOutput();
        s_cpu_ack   = cpu_ack;
        s_ld_ack    = ld_ack;
        s_ram_we    = ram_we;
        s_cpu_stall = cpu_stall;
        s_ram_addr  = 32'(ram_addr);
        s_ram_din   = ram_din;
        s_cpu_rdata = cpu_rdata;
        s_ld_rdata  = ld_rdata;
        chk("cpu_ack",   32'(s_cpu_ack),   32'(e_cpu_ack));
        chk("ld_ack",    32'(s_ld_ack),    32'(e_ld_ack));
        chk("ram_we",    32'(s_ram_we),    32'(e_ram_we));
        chk("cpu_stall", 32'(s_cpu_stall), 32'(e_cpu_stall));
        chk("ram_addr",  s_ram_addr,  e_ram_addr);
        chk("ram_din",   s_ram_din,   e_ram_din);
        chk("cpu_rdata", s_cpu_rdata, e_cpu_rdata);
        chk("ld_rdata",  s_ld_rdata,  e_ld_rdata);
    endtask

    // One cycle: check at the falling edge, return just after the next
    // rising edge so the caller can drive the following cycle's inputs.
    task automatic tick();
        @(negedge clk);
        modelStep();
        checkOutput();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random requesters: hold each request until its ack, then either issue
    // a fresh back-to-back request or go quiet for a while.
    task automatic applyStimulus();
        if (cpu_req) begin
            if (s_cpu_ack) begin
                if ($urandom_range(0, 3) != 0) begin
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_addr  = $urandom;
                    cpu_wdata = $urandom;
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end else if ($urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
        end
        if (ld_req) begin
            if (s_ld_ack) begin
                if ($urandom_range(0, 2) != 0) begin
                    ld_we    = 1'($urandom_range(0, 1));
                    ld_addr  = $urandom;
                    ld_wdata = $urandom;
                end else begin
                    ld_req = 1'b0;
                end
            end
        end else if ($urandom_range(0, 3) == 0) begin
            ld_req   = 1'b1;
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = $urandom;
            ld_wdata = $urandom;
        end
    endtask

    initial begin
        int cpuAcks, ldAcks, firstLd, secondLd, weCount, n, lastAck;

        for (int i = 0; i < WORDS; i++) mem[i] = initWord(i);

        // Reset and preload.
        #1 reset = 1'b0;
        tick();
        tick();
        chk("rst_cpu_ack",   32'(s_cpu_ack), 0);
        chk("rst_ld_ack",    32'(s_ld_ack), 0);
        chk("rst_ram_we",    32'(s_ram_we), 0);
        chk("rst_ram_addr",  s_ram_addr, 0);
        chk("rst_ram_din",   s_ram_din, 0);
        chk("rst_cpu_rdata", s_cpu_rdata, 0);
        chk("rst_ld_rdata",  s_ld_rdata, 0);
        reset   = 1'b1;
        preload = 1'b0;
        tick();

        // CPU read alone of word 5.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
        tick();
        chk("rd_stall_t0", 32'(s_cpu_stall), 1);
        tick();
        chk("rd_ram_addr_t1", s_ram_addr, 5);
        chk("rd_stall_t1", 32'(s_cpu_stall), 1);
        tick();
        chk("rd_ack_t2", 32'(s_cpu_ack), 1);
        chk("rd_data_t2", s_cpu_rdata, 32'hDEADBEEF);
        chk("rd_stall_t2", 32'(s_cpu_stall), 0);
        cpu_req = 1'b0;
        tick();

        // CPU write then read back through an unaligned address.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
        weCount = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            weCount += int'(s_ram_we);
            if (k == 1) begin
                chk("wr_ram_addr", s_ram_addr, 16);
                chk("wr_ram_din", s_ram_din, 32'h12345678);
            end
        end
        chk("wr_ack", 32'(s_cpu_ack), 1);
        chk("wr_rdata_zero", s_cpu_rdata, 0);
        cpu_req = 1'b0;
        tick();
        weCount += int'(s_ram_we);
        chk("wr_we_pulses", weCount, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h43;
        tick(); tick(); tick();
        chk("rdback_data", s_cpu_rdata, 32'h12345678);
        cpu_req = 1'b0;
        tick();

        // Contention: both held, loader forced through every fifth grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 32'h200;
        cpuAcks = 0; ldAcks = 0; firstLd = -1; secondLd = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (s_cpu_ack) cpuAcks++;
            if (s_ld_ack) begin
                ldAcks++;
                if (firstLd < 0) firstLd = k;
                else secondLd = k;
            end
            if (k >= 12 && k <= 14) chk("contend_stall_ld", 32'(s_cpu_stall), 1);
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        chk("contend_cpu_acks", cpuAcks, 8);
        chk("contend_ld_acks", ldAcks, 2);
        chk("contend_first_ld", firstLd, 14);
        chk("contend_second_ld", secondLd, 29);

        // Loader alone, back-to-back writes to words 0..7.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'd0; ld_wdata = 32'hC0DE0000;
        n = 0; lastAck = -1;
        for (int k = 0; k < 30 && n < 8; k++) begin
            tick();
            if (s_ld_ack) begin
                if (n > 0) chk("ld_spacing", k - lastAck, 3);
                lastAck = k;
                n++;
                ld_addr  = 32'(4 * n);
                ld_wdata = 32'hC0DE0000 + 32'(n);
                if (n == 8) ld_req = 1'b0;
            end
        end
        ld_req = 1'b0;
        tick();
        chk("ld_ack_count", n, 8);
        for (int i = 0; i < 8; i++) chk("ld_ram_word", ram[i], 32'hC0DE0000 + 32'(i));

        // Address wrap: 0x2004 lands on word 1.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2004;
        tick(); tick();
        chk("wrap_ram_addr", s_ram_addr, 1);
        tick();
        chk("wrap_data", s_cpu_rdata, 32'hC0DE0001);
        cpu_req = 1'b0;
        tick();

        // Reset during the ACCESS cycle of a CPU write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFEF00D;
        tick();
        chk("mid_we_before", 32'(ram_we), 1);
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        chk("mid_we_dropped", 32'(ram_we), 0);
        chk("mid_ram_addr", 32'(ram_addr), 0);
        chk("mid_cpu_rdata", cpu_rdata, 0);
        tick(); tick();
        chk("mid_no_ack", 32'(s_cpu_ack), 0);
        reset = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        tick(); tick(); tick();
        chk("mid_old_data", s_cpu_rdata, initWord(32));
        cpu_req = 1'b0;
        tick();

        // Randomized traffic from both requesters.
        for (int k = 0; k < 1500; k++) begin
            applyStimulus();
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
